// File: rtl/riscv_dmi_arbiter.sv
// riscv_dmi_arbiter
//   Shares one Debug Module DMI port between two requesters (0 = JTAG DTM,
//   1 = system bus bridge), with exactly one transaction outstanding.
//   Flow: IDLE (grant/accept) -> REQ (drive DM) -> RESP (collect DM
//   response) -> DELIVER (hand response back to the owner).
//
// Optional feature: define RISCV_DMI_ARB_TIMEOUT_EN for a RESP watchdog.
//   After TIMEOUT_CYCLES RESP cycles without a DM response it delivers
//   data = 0, op = 2 (failed). In that build dm_resp_ready_o is also high in
//   IDLE and REQ so late DM responses are drained and dropped.
//
// Ports
//   clk_i, rstn_i                      clock, async active-low reset
//   req_valid_i/req_ready_o     [1:0]  per-requester request handshake
//   req_addr_i/data_i/op_i      [1:0]  per-requester request payload
//   resp_valid_o/resp_ready_i   [1:0]  per-requester response handshake
//   resp_data_o/resp_op_o              shared response payload
//   dm_req_*                           DM-side request channel
//   dm_resp_*                          DM-side response channel
module riscv_dmi_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int DMI_ADDR_WIDTH = 7,
  parameter int DMI_DATA_WIDTH = 32,
  parameter int DMI_OP_WIDTH   = 2
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic [1:0]                     req_valid_i,
  output logic [1:0]                     req_ready_o,
  input  logic [1:0][DMI_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [1:0][DMI_DATA_WIDTH-1:0] req_data_i,
  input  logic [1:0][DMI_OP_WIDTH-1:0]   req_op_i,
  output logic [1:0]                     resp_valid_o,
  input  logic [1:0]                     resp_ready_i,
  output logic [DMI_DATA_WIDTH-1:0]      resp_data_o,
  output logic [DMI_OP_WIDTH-1:0]        resp_op_o,
  output logic                           dm_req_valid_o,
  input  logic                           dm_req_ready_i,
  output logic [DMI_ADDR_WIDTH-1:0]      dm_req_addr_o,
  output logic [DMI_DATA_WIDTH-1:0]      dm_req_data_o,
  output logic [DMI_OP_WIDTH-1:0]        dm_req_op_o,
  input  logic                           dm_resp_valid_i,
  output logic                           dm_resp_ready_o,
  input  logic [DMI_DATA_WIDTH-1:0]      dm_resp_data_i,
  input  logic [DMI_OP_WIDTH-1:0]        dm_resp_op_i
);

  if (TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("riscv_dmi_arbiter: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DELIVER} state_e;

  state_e                    r_state, w_next;
  logic                      r_ptr, r_owner;
  logic [DMI_ADDR_WIDTH-1:0] r_addr;
  logic [DMI_DATA_WIDTH-1:0] r_data, r_rdata;
  logic [DMI_OP_WIDTH-1:0]   r_op, r_rop;
  logic                      w_grant, w_accept, w_timeout;

  // Round-robin pointer only matters on contention; a lone requester wins.
  // Reset gates acceptance so req_ready_o stays low while rstn_i is low.
  assign w_grant  = (&req_valid_i) ? r_ptr : req_valid_i[1];
  assign w_accept = (r_state == S_IDLE) && (|req_valid_i) && rstn_i;

`ifdef RISCV_DMI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [DMI_OP_WIDTH-1:0] RD_OP_FAILED = DMI_OP_WIDTH'(2);
  logic [CNT_W-1:0] r_cnt;

  // Counter holds the number of RESP cycles already spent; firing at
  // TIMEOUT_CYCLES-1 ends RESP after exactly TIMEOUT_CYCLES cycles.
  assign w_timeout = (r_state == S_RESP) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                                  r_cnt <= '0;
    else if (r_state == S_REQ && dm_req_ready_i)  r_cnt <= '0;
    else if (r_state == S_RESP)                   r_cnt <= r_cnt + CNT_W'(1);
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next          = r_state;
    req_ready_o     = '0;
    dm_req_valid_o  = 1'b0;
    dm_resp_ready_o = 1'b0;
    resp_valid_o    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          req_ready_o[w_grant] = 1'b1;
          w_next               = S_REQ;
        end
`ifdef RISCV_DMI_ARB_TIMEOUT_EN
        dm_resp_ready_o = rstn_i;  // drain stale responses
`endif
      end
      S_REQ: begin
        dm_req_valid_o = 1'b1;
        if (dm_req_ready_i) w_next = S_RESP;
`ifdef RISCV_DMI_ARB_TIMEOUT_EN
        dm_resp_ready_o = 1'b1;
`endif
      end
      S_RESP: begin
        dm_resp_ready_o = 1'b1;
        if (dm_resp_valid_i || w_timeout) w_next = S_DELIVER;
      end
      S_DELIVER: begin
        resp_valid_o[r_owner] = 1'b1;
        if (resp_ready_i[r_owner]) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
      r_ptr   <= 1'b0;
      r_owner <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_op    <= '0;
      r_rdata <= '0;
      r_rop   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_owner <= w_grant;
        r_addr  <= req_addr_i[w_grant];
        r_data  <= req_data_i[w_grant];
        r_op    <= req_op_i[w_grant];
      end
      // A real response wins over a coincident timeout.
      if (r_state == S_RESP) begin
        if (dm_resp_valid_i) begin
          r_rdata <= dm_resp_data_i;
          r_rop   <= dm_resp_op_i;
        end else if (w_timeout) begin
          r_rdata <= '0;
`ifdef RISCV_DMI_ARB_TIMEOUT_EN
          r_rop   <= RD_OP_FAILED;
`endif
        end
      end
      if (r_state == S_DELIVER && resp_ready_i[r_owner]) r_ptr <= ~r_owner;
    end
  end

  assign dm_req_addr_o = r_addr;
  assign dm_req_data_o = r_data;
  assign dm_req_op_o   = r_op;
  assign resp_data_o   = r_rdata;
  assign resp_op_o     = r_rop;

endmodule

// File: tb/tb_riscv_dmi_arbiter.sv
module tb_riscv_dmi_arbiter;
  localparam int AW = 7, DW = 32, OW = 2, TO = 8;
`ifdef RISCV_DMI_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic               clk_i = 1'b0, rstn_i = 1'b0;
  logic [1:0]         req_valid_i = '0, req_ready_o;
  logic [1:0][AW-1:0] req_addr_i = '0;
  logic [1:0][DW-1:0] req_data_i = '0;
  logic [1:0][OW-1:0] req_op_i = '0;
  logic [1:0]         resp_valid_o, resp_ready_i = '0;
  logic [DW-1:0]      resp_data_o;
  logic [OW-1:0]      resp_op_o;
  logic               dm_req_valid_o, dm_req_ready_i = 1'b0;
  logic [AW-1:0]      dm_req_addr_o;
  logic [DW-1:0]      dm_req_data_o;
  logic [OW-1:0]      dm_req_op_o;
  logic               dm_resp_valid_i = 1'b0, dm_resp_ready_o;
  logic [DW-1:0]      dm_resp_data_i = '0;
  logic [OW-1:0]      dm_resp_op_i = '0;

  riscv_dmi_arbiter #(.TIMEOUT_CYCLES(TO), .DMI_ADDR_WIDTH(AW),
                      .DMI_DATA_WIDTH(DW), .DMI_OP_WIDTH(OW)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_op_i(req_op_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o), .resp_op_o(resp_op_o),
    .dm_req_valid_o(dm_req_valid_o), .dm_req_ready_i(dm_req_ready_i),
    .dm_req_addr_o(dm_req_addr_o), .dm_req_data_o(dm_req_data_o),
    .dm_req_op_o(dm_req_op_o),
    .dm_resp_valid_i(dm_resp_valid_i), .dm_resp_ready_o(dm_resp_ready_o),
    .dm_resp_data_i(dm_resp_data_i), .dm_resp_op_i(dm_resp_op_i));

  always #5 clk_i = ~clk_i;

  // Reference model: round-robin pointer plus last delivered response.
  int            n_chk = 0, n_fail = 0;
  logic          m_ptr = 1'b0;
  logic [DW-1:0] m_last_d = '0;
  logic [OW-1:0] m_last_op = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic reset_pulse();
    rstn_i = 1'b0; req_valid_i = 2'b11; resp_ready_i = 2'b11; dm_resp_valid_i = 1'b1;
    #1;
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_dm_req_valid", dm_req_valid_o, 0);
    chk("rst_dm_resp_ready", dm_resp_ready_o, 0);
    chk("rst_dm_addr", dm_req_addr_o, 0);
    chk("rst_dm_data", dm_req_data_o, 0);
    chk("rst_dm_op", dm_req_op_o, 0);
    chk("rst_resp_data", resp_data_o, 0);
    chk("rst_resp_op", resp_op_o, 0);
    tick();
    req_valid_i = '0; resp_ready_i = '0; dm_resp_valid_i = 1'b0;
    rstn_i = 1'b1;
    m_ptr = 1'b0; m_last_d = '0; m_last_op = '0;
  endtask

  // One complete transaction with chosen wait states; every cycle is checked.
  task automatic do_txn(input logic [1:0] vm, input logic [AW-1:0] a0, a1,
                        input logic [DW-1:0] d0, d1, input logic [OW-1:0] o0, o1,
                        input int dmw, rspw, rdyw,
                        input logic [DW-1:0] rd, input logic [OW-1:0] ro,
                        output int cycles);
    logic          g;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [OW-1:0] eo;
    g  = (vm == 2'b11) ? m_ptr : vm[1];
    ea = g ? a1 : a0; ed = g ? d1 : d0; eo = g ? o1 : o0;
    req_valid_i = vm;
    req_addr_i[0] = a0; req_addr_i[1] = a1;
    req_data_i[0] = d0; req_data_i[1] = d1;
    req_op_i[0]   = o0; req_op_i[1]   = o1;
    #1;
    chk("idle_grant", req_ready_o, 2'b01 << g);
    chk("idle_resp_valid", resp_valid_o, 0);
    chk("idle_hold_data", resp_data_o, m_last_d);
    chk("idle_hold_op", resp_op_o, m_last_op);
    chk("idle_dm_resp_ready", dm_resp_ready_o, TO_EN);
    tick(); cycles = 1;
    req_valid_i[g] = 1'b0;
    req_addr_i = '0; req_data_i = '0; req_op_i = '0;  // latched copy must hold
    for (int i = 0; i <= dmw; i++) begin
      dm_req_ready_i = (i == dmw);
      req_valid_i[~g] = 1'($urandom_range(0, 1));  // never granted outside IDLE
      #1;
      chk("req_valid", dm_req_valid_o, 1);
      chk("req_addr", dm_req_addr_o, ea);
      chk("req_data", dm_req_data_o, ed);
      chk("req_op", dm_req_op_o, eo);
      chk("req_no_grant", req_ready_o, 0);
      chk("req_resp_valid", resp_valid_o, 0);
      tick(); cycles++;
    end
    dm_req_ready_i = 1'b0;
    for (int i = 0; i <= rspw; i++) begin
      dm_resp_valid_i = (i == rspw);
      dm_resp_data_i  = (i == rspw) ? rd : DW'($urandom);
      dm_resp_op_i    = (i == rspw) ? ro : OW'($urandom);
      #1;
      if (i < 4 || i == rspw) begin
        chk("resp_dm_ready", dm_resp_ready_o, 1);
        chk("resp_no_req", dm_req_valid_o, 0);
        chk("resp_no_deliver", resp_valid_o, 0);
        chk("resp_no_grant", req_ready_o, 0);
      end
      tick(); cycles++;
    end
    dm_resp_valid_i = 1'b0;
    for (int i = 0; i <= rdyw; i++) begin
      resp_ready_i[g]  = (i == rdyw);
      resp_ready_i[~g] = 1'($urandom_range(0, 1));
      #1;
      chk("dlv_valid", resp_valid_o, 2'b01 << g);
      chk("dlv_data", resp_data_o, rd);
      chk("dlv_op", resp_op_o, ro);
      chk("dlv_no_grant", req_ready_o, 0);
      tick(); cycles++;
    end
    resp_ready_i = '0; req_valid_i = '0;
    m_ptr = ~g; m_last_d = rd; m_last_op = ro;
  endtask

  initial begin
    int cyc;
    tick(); tick();
    reset_pulse();

    // Single JTAG request, zero-wait peers: 4-cycle round trip.
    do_txn(2'b01, 7'h10, 7'h00, 32'hDEADBEEF, 32'h0, 2'd2, 2'd0, 0, 0, 0, 32'h1234, 2'd0, cyc);
    chk("round_trip_cycles", cyc, 4);

    // Continuous contention after reset: grants alternate 0,1,0,1.
    reset_pulse();
    for (int t = 0; t < 4; t++) begin
      do_txn(2'b11, 7'(t), 7'(t + 8), DW'($urandom), DW'($urandom), 2'd1, 2'd2,
             0, 0, 0, DW'($urandom), 2'd0, cyc);
      chk("contention_ptr", m_ptr, (t % 2 == 0) ? 1 : 0);
    end

    // Back-pressure on both sides for requester 1.
    do_txn(2'b10, 7'h22, 7'h33, 32'h11111111, 32'hCAFEF00D, 2'd1, 2'd2,
           5, 0, 3, 32'hA5A5A5A5, 2'd0, cyc);
    chk("backpressure_cycles", cyc, 1 + 6 + 1 + 4);

    // Randomized traffic.
    for (int t = 0; t < 25; t++) begin
      logic [1:0] vm;
      vm = 2'($urandom_range(1, 3));
      do_txn(vm, AW'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
             OW'($urandom), OW'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), DW'($urandom), OW'($urandom), cyc);
    end

`ifdef RISCV_DMI_ARB_TIMEOUT_EN
    // Silent DM: failed response after TO RESP cycles, late response drained.
    req_valid_i = 2'b01; req_addr_i[0] = 7'h05; req_data_i[0] = 32'h77; req_op_i[0] = 2'd1;
    #1; chk("to_grant", req_ready_o, 2'b01);
    tick(); req_valid_i = '0; dm_req_ready_i = 1'b1;
    #1; chk("to_dm_req", dm_req_valid_o, 1);
    tick(); dm_req_ready_i = 1'b0;
    for (int i = 0; i < TO; i++) begin
      #1; chk("to_wait", resp_valid_o, 0);
      tick();
    end
    #1;
    chk("to_valid", resp_valid_o, 2'b01);
    chk("to_data", resp_data_o, 0);
    chk("to_op", resp_op_o, 2);
    resp_ready_i = 2'b01;
    tick(); resp_ready_i = '0;
    m_ptr = 1'b1; m_last_d = '0; m_last_op = 2'd2;
    dm_resp_valid_i = 1'b1; dm_resp_data_i = 32'hBAD; dm_resp_op_i = 2'd0;
    #1;
    chk("late_drained", dm_resp_ready_o, 1);
    chk("late_not_delivered", resp_valid_o, 0);
    tick(); dm_resp_valid_i = 1'b0;
    #1; chk("late_still_idle", resp_valid_o, 0);
    // Response arriving on the timeout cycle is the real one.
    do_txn(2'b01, 7'h06, 7'h0, 32'h1, 32'h0, 2'd1, 2'd0, 0, TO - 1, 0, 32'h600D, 2'd0, cyc);
`else
    // Slow DM: arbiter waits in RESP and delivers the real data.
    do_txn(2'b01, 7'h07, 7'h0, 32'h2, 32'h0, 2'd1, 2'd0, 0, 2000, 0, 32'h5EED1234, 2'd0, cyc);
    chk("slow_dm_cycles", cyc, 1 + 1 + 2001 + 1);
`endif

    // Reset while in RESP: discarded, then a fresh req1 is granted.
    req_valid_i = 2'b01; req_addr_i[0] = 7'h0A; req_data_i[0] = 32'h99; req_op_i[0] = 2'd1;
    tick(); req_valid_i = '0; dm_req_ready_i = 1'b1;
    tick(); dm_req_ready_i = 1'b0;
    #1; chk("pre_rst_in_resp", dm_resp_ready_o, 1);
    reset_pulse();
    #1;
    chk("post_rst_no_resp", resp_valid_o, 0);
    chk("post_rst_no_req", dm_req_valid_o, 0);
    tick();
    do_txn(2'b10, 7'h0, 7'h3C, 32'h0, 32'h12345678, 2'd0, 2'd1, 0, 0, 0, 32'h87654321, 2'd0, cyc);
    do_txn(2'b11, 7'h01, 7'h02, 32'h3, 32'h4, 2'd1, 2'd1, 1, 1, 1, 32'hFEEDFACE, 2'd0, cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/riscv_dmi_arbiter.md
RISCV_DMI_ARBITER -- requirements
Module: riscv_dmi_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, is the response-timeout limit in clk_i cycles and SHALL be at least 2.
REQ-002 clk_i  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rstn_i  in  1  reset; asynchronous, active-low.
REQ-004 req_valid_i  in  2  per-requester request valid (index 0 = JTAG DTM, 1 = system bus bridge).
REQ-005 req_ready_o  out  2  per-requester request accept.
REQ-006 req_addr_i / req_data_i / req_op_i  in  2 x DMI_ADDR_WIDTH / 2 x DMI_DATA_WIDTH / 2 x DMI_OP_WIDTH  per-requester payload.
REQ-007 resp_valid_o  out  2  per-requester response valid; resp_ready_i  in  2  per-requester response accept.
REQ-008 resp_data_o / resp_op_o  out  DMI_DATA_WIDTH / DMI_OP_WIDTH  shared response payload.
REQ-009 dm_req_valid_o  out  1, dm_req_ready_i  in  1, dm_req_addr_o / dm_req_data_o / dm_req_op_o  out  DM-side request channel.
REQ-010 dm_resp_valid_i  in  1, dm_resp_ready_o  out  1, dm_resp_data_i / dm_resp_op_i  in  DM-side response channel.

Function
REQ-011 The block SHALL share one DM DMI port between two requesters with exactly one transaction outstanding.
REQ-012 FSM states SHALL be IDLE, REQ, RESP, DELIVER.
REQ-013 IDLE: if any req_valid_i is high, a grant SHALL be chosen combinationally; req_ready_o[grant] = 1 in that cycle; payload and owner latched; next state REQ.
REQ-014 With both req_valid_i high in IDLE, grant SHALL go to the index equal to the round-robin pointer; with one high, that one wins.
REQ-015 REQ: dm_req_valid_o = 1 with latched payload, stable until dm_req_ready_i = 1; then next state RESP.
REQ-016 RESP: dm_resp_ready_o = 1; on dm_resp_valid_i, dm_resp_data_i/dm_resp_op_i SHALL be latched; next state DELIVER.
REQ-017 DELIVER: resp_valid_o[owner] = 1 with latched data/op; on resp_ready_i[owner] the next state SHALL be IDLE and pointer = ~owner.
REQ-018 Minimum round trip SHALL be 4 cycles (accept, DM accept, DM response, delivery) with zero-wait peers.
REQ-019 req_ready_o SHALL be 0 outside IDLE; resp_valid_o[~owner] SHALL always be 0.
REQ-020 Payload SHALL pass unmodified; resp_data_o/resp_op_o SHALL hold their last latched value outside DELIVER.
REQ-021 A requester dropping req_valid_i without ready SHALL have no effect; it is never granted retroactively.

Reset
REQ-022 rstn_i low SHALL force IDLE, pointer = 0, owner = 0, latched payload/response = 0, counter = 0.
REQ-023 During reset all *_valid_o, req_ready_o and dm_resp_ready_o SHALL be 0, all data/op outputs 0.
REQ-024 Reset mid-transaction SHALL discard it; no response is delivered for it after reset release.

Configuration
REQ-025 Macro RISCV_DMI_ARB_TIMEOUT_EN SHALL enable a response watchdog.
REQ-026 With it: counter cleared on RESP entry, incremented each RESP cycle; at TIMEOUT_CYCLES without dm_resp_valid_i, latch data = 0, op = RD_OP_FAILED (2), go DELIVER.
REQ-027 With it: dm_resp_ready_o SHALL also be 1 in IDLE and REQ, discarding any late response there; dm_resp_valid_i and timeout in the same cycle SHALL take the real response.
REQ-028 Without it: no counter logic exists; dm_resp_ready_o = 1 only in RESP; RESP waits indefinitely.

Verification
REQ-029 Req0 only, addr 0x10 data 0xDEADBEEF op 2, DM zero-wait returns 0x1234 op 0 -> dm_req_* match, resp_valid_o = 01, resp_data_o 0x1234, 4 cycles.
REQ-030 Both requesters valid continuously for 4 transactions after reset -> grants 0,1,0,1.
REQ-031 dm_req_ready_i held low 5 cycles, resp_ready_i[1] low 3 cycles -> payloads stable, no second grant, req_ready_o = 00 throughout.
REQ-032 rstn_i asserted in RESP -> outputs 0 immediately; after release, new req1 granted with pointer 0 rule and no stale response.
REQ-033 Macro on, TIMEOUT_CYCLES 8, DM silent -> after 8 RESP cycles resp_op_o = 2, resp_data_o = 0; late DM response in IDLE consumed, not delivered.
REQ-034 Macro off, DM response delayed 2000 cycles -> arbiter stays in RESP, then delivers correct data.
